// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for the async FIFO write port.
// Round-robin grants with bounded bursts and wr_full backpressure.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int SRC_W     = 2
) (
    input  logic                      clk_wr,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      wr_full,
    output logic                      wr_en,
    output logic [DATA_W-1:0]         wr_data,
    output logic [SRC_W-1:0]          wr_src,
    output logic                      busy
);

    localparam int BC_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state, state_nxt;
    logic [SRC_W-1:0]  owner, owner_nxt;
    logic [SRC_W-1:0]  last_owner, last_nxt;
    logic [BC_W-1:0]   beat_cnt, beat_nxt;

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [SRC_W-1:0]     rr_pick;
    logic                 any_req;

    logic              cur_valid;
    logic              cur_last;
    logic [DATA_W-1:0] cur_data;
    logic              xfer;
    logic              burst_end;

    // Round-robin pick: rotate so last_owner+1 is bit 0, take lowest set bit.
    always_comb begin
        dbl     = {req_valid, req_valid};
        rot     = NUM_REQ'(dbl >> (int'(last_owner) + 1));
        rr_pick = '0;
        any_req = |req_valid;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                rr_pick = SRC_W'((int'(last_owner) + 1 + i) % NUM_REQ);
            end
        end
    end

    // Select the current owner's valid/last/data lanes.
    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == SRC_W'(i)) begin
                cur_valid = req_valid[i];
                cur_last  = req_last[i];
                cur_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // State and arbitration registers; reset gives requester 0 first turn.
    always_ff @(posedge clk_wr or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= SRC_W'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_nxt;
            beat_cnt   <= beat_nxt;
        end
    end

    // Next-state and outputs; a full FIFO freezes the grant without release.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last_owner;
        beat_nxt  = beat_cnt;
        req_ready = '0;
        wr_en     = 1'b0;
        wr_data   = '0;
        wr_src    = '0;
        busy      = 1'b0;
        xfer      = 1'b0;
        burst_end = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    owner_nxt = rr_pick;
                    beat_nxt  = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                busy   = 1'b1;
                wr_src = owner;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (owner == SRC_W'(i)) begin
                        req_ready[i] = ~wr_full;
                    end
                end
                xfer  = cur_valid & ~wr_full;
                wr_en = xfer;
                if (xfer) begin
                    wr_data  = cur_data;
                    beat_nxt = beat_cnt + BC_W'(1);
                end
                burst_end = cur_last ||
                            (beat_cnt == BC_W'(MAX_BURST - 1));
                if ((xfer && burst_end) || (!cur_valid && !wr_full)) begin
                    state_nxt = IDLE;
                    last_nxt  = owner;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
